// File: rtl/btn_ctrl_pkg.sv
// Shared defaults, per-channel event bundle and counter sizing helpers
// for the multi-channel button controller.
package btn_ctrl_pkg;

  localparam int DEF_N_BTN             = 2;
  localparam int DEF_MIN_PULSE_WIDTH   = 25000;
  localparam int DEF_ACTIVE_LOW        = 1;
  localparam int DEF_LONG_PRESS_CYCLES = 40000000;
  localparam int DEF_REPEAT_DELAY      = 20000000;
  localparam int DEF_REPEAT_PERIOD     = 4000000;

  typedef struct packed {
    logic lvl;
    logic press;
    logic rel;
    logic lng;
    logic rpt;
  } chan_evt_t;

  // Bits needed to hold the terminal value of a counter (min 1).
  function automatic int cnt_w(input int term);
    return (term < 2) ? 1 : $clog2(term + 1);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_ctrl_chan.sv
// One button channel: 2-flop sync, debounce, press/release edges,
// saturating hold timer with long-press pulse and auto-repeat train.
module btn_ctrl_chan
  import btn_ctrl_pkg::*;
#(
  parameter int MIN_PULSE_WIDTH   = DEF_MIN_PULSE_WIDTH,
  parameter int ACTIVE_LOW        = DEF_ACTIVE_LOW,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int REPEAT_DELAY      = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD     = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN         = 1'b1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_btn,
  output chan_evt_t o_evt
);

  localparam logic RAW_IDLE = (ACTIVE_LOW != 0);
  localparam int   DW = cnt_w(MIN_PULSE_WIDTH);
  localparam int   HW = cnt_w(LONG_PRESS_CYCLES);
  localparam int   RW = cnt_w(imax(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] DB_LAST = DW'(MIN_PULSE_WIDTH - 1);
  localparam logic [HW-1:0] H_TERM  = HW'(LONG_PRESS_CYCLES);
  localparam logic [RW-1:0] R_DLY   = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PER   = RW'(REPEAT_PERIOD);

  logic [1:0]    sync;
  logic          stable;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] h_cnt, h_nx;
  logic [RW-1:0] r_cnt, r_nx;
  logic          r_first;
  logic          press, rel, lng, rpt;
  logic          smp, flip, r_hit;

  assign smp   = sync[1] ^ RAW_IDLE;
  assign flip  = (smp != stable) && (db_cnt == DB_LAST);
  assign h_nx  = (h_cnt == H_TERM) ? h_cnt : h_cnt + HW'(1);
  assign r_nx  = r_cnt + RW'(1);
  // First repeat waits the longer delay, later ones the period.
  assign r_hit = r_first ? (r_nx == R_DLY) : (r_nx == R_PER);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync    <= {2{RAW_IDLE}};
      stable  <= 1'b0;
      db_cnt  <= '0;
      h_cnt   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      lng     <= 1'b0;
      rpt     <= 1'b0;
    end else begin
      sync   <= {sync[0], i_btn};
      press  <= flip & ~stable;
      rel    <= flip & stable;
      lng    <= 1'b0;
      rpt    <= 1'b0;
      db_cnt <= ((smp == stable) || flip) ? '0 : db_cnt + DW'(1);
      if (flip) stable <= ~stable;

      if (flip && !stable) begin
        h_cnt   <= '0;
        r_cnt   <= '0;
        r_first <= 1'b1;
        rpt     <= REPEAT_EN;
      end else if (stable && !flip) begin
        h_cnt <= h_nx;
        lng   <= (h_cnt != H_TERM) && (h_nx == H_TERM);
        if (r_hit) begin
          rpt     <= REPEAT_EN;
          r_cnt   <= '0;
          r_first <= 1'b0;
        end else begin
          r_cnt <= r_nx;
        end
      end else begin
        // Released, or the release cycle itself: timers idle, no pulses.
        h_cnt   <= '0;
        r_cnt   <= '0;
        r_first <= 1'b0;
      end
    end
  end

  assign o_evt = '{lvl: stable, press: press, rel: rel, lng: lng, rpt: rpt};

endmodule

// File: rtl/btn_ctrl_multi.sv
// N_BTN independent debounced button channels with press/release,
// long-press and auto-repeat pulses.
module btn_ctrl_multi
  import btn_ctrl_pkg::*;
#(
  parameter int               N_BTN             = DEF_N_BTN,
  parameter int               MIN_PULSE_WIDTH   = DEF_MIN_PULSE_WIDTH,
  parameter int               ACTIVE_LOW        = DEF_ACTIVE_LOW,
  parameter int               LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int               REPEAT_DELAY      = DEF_REPEAT_DELAY,
  parameter int               REPEAT_PERIOD     = DEF_REPEAT_PERIOD,
  parameter logic [N_BTN-1:0] REPEAT_EN         = '1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long,
  output logic [N_BTN-1:0] o_repeat
);

  chan_evt_t [N_BTN-1:0] evt;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_ctrl_chan #(
      .MIN_PULSE_WIDTH  (MIN_PULSE_WIDTH),
      .ACTIVE_LOW       (ACTIVE_LOW),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_DELAY     (REPEAT_DELAY),
      .REPEAT_PERIOD    (REPEAT_PERIOD),
      .REPEAT_EN        (REPEAT_EN[g])
    ) u_chan (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_btn(i_btn[g]),
      .o_evt(evt[g])
    );

    assign o_btn[g]     = evt[g].lvl;
    assign o_press[g]   = evt[g].press;
    assign o_release[g] = evt[g].rel;
    assign o_long[g]    = evt[g].lng;
    assign o_repeat[g]  = evt[g].rpt;
  end

endmodule

// File: tb/tb_btn_ctrl_multi.sv
// Directed bench for btn_ctrl_multi with small timing parameters;
// expected pulses derived from press/release cycle arithmetic.
module tb_btn_ctrl_multi;

  localparam int MPW = 4;
  localparam int LPC = 20;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = 2 + MPW;
  localparam logic [1:0] REN = 2'b01;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [1:0] i_btn;
  logic [1:0] o_btn, o_press, o_release, o_long, o_repeat;

  int n_vec = 0;
  int n_err = 0;

  btn_ctrl_multi #(
    .N_BTN(2), .MIN_PULSE_WIDTH(MPW), .ACTIVE_LOW(1),
    .LONG_PRESS_CYCLES(LPC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_EN(REN)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn),
    .o_btn(o_btn), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_repeat(o_repeat)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc %0d: observed %b expected %b", tag, c, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_btn"}, 0, o_btn, 2'b00);
    chk({tag, "_press"}, 0, o_press, 2'b00);
    chk({tag, "_rel"}, 0, o_release, 2'b00);
    chk({tag, "_long"}, 0, o_long, 2'b00);
    chk({tag, "_rep"}, 0, o_repeat, 2'b00);
  endtask

  // h = cycles since press
  function automatic bit rep_at(input int h);
    return (h == 0) || (h == RD) || ((h > RD) && ((h - RD) % RP == 0));
  endfunction

  // Cycle 0 is the cycle the caller changed i_btn (or dropped reset).
  // Channels in mask are expected to press at LAT; raw release of
  // rel_bits happens at cycle rel_raw.
  task automatic window(input logic [1:0] mask, input logic [1:0] rel_bits,
                        input int rel_raw, input int ncyc);
    logic [1:0] eb, ep, er, el, et;
    bit held;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        held  = mask[i] && (c >= LAT) && (c < rel_raw + LAT);
        eb[i] = held;
        ep[i] = mask[i] && (c == LAT);
        er[i] = mask[i] && (c == rel_raw + LAT);
        el[i] = held && (c == LAT + LPC);
        et[i] = held && REN[i] && rep_at(c - LAT);
      end
      chk("btn", c, o_btn, eb);
      chk("press", c, o_press, ep);
      chk("release", c, o_release, er);
      chk("long", c, o_long, el);
      chk("repeat", c, o_repeat, et);
      if (c == rel_raw) i_btn = i_btn | rel_bits;
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_btn = 2'b11;
    tick();
    tick();
    chk_zero("reset");
    i_rst = 1'b0;
    tick();
    tick();
    chk_zero("idle");

    // long hold: press 6, repeats 6,16,19,..., long 26, release 56
    i_btn[0] = 1'b0;
    window(2'b01, 2'b01, 50, 60);

    // 3-cycle glitch: nothing
    i_btn[0] = 1'b0;
    window(2'b00, 2'b01, 3, 12);

    // exactly MIN_PULSE_WIDTH low: accepted
    i_btn[0] = 1'b0;
    window(2'b01, 2'b01, 4, 14);

    // released 15 cycles after P: no long, no repeat after release
    i_btn[0] = 1'b0;
    window(2'b01, 2'b01, 15, 26);

    // simultaneous press, repeat only on bit 0
    i_btn = 2'b00;
    window(2'b11, 2'b11, 12, 22);

    // reset at P+5 while held, then fresh press after deassertion
    i_btn[0] = 1'b0;
    window(2'b01, 2'b01, 999, 11);
    i_rst = 1'b1;
    #1;
    chk_zero("rst_async");
    tick();
    chk_zero("rst_hold");
    i_rst = 1'b0;
    window(2'b01, 2'b01, 28, 36);

    // reset mid-debounce on channel 1: no event afterwards
    i_btn[1] = 1'b0;
    tick();
    tick();
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    chk_zero("rst_db");
    i_btn = 2'b11;
    i_rst = 1'b0;
    window(2'b00, 2'b00, 999, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_ctrl_multi.md
BTN_CTRL_MULTI -- requirements
Module: btn_ctrl_multi

Interface
REQ-001 SHALL have parameter N_BTN, default 2, meaning the number of independent button channels (1..16).
REQ-002 SHALL have parameter MIN_PULSE_WIDTH, default 25000, meaning the number of consecutive stable cycles before a level change is accepted (>=2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, meaning raw inputs read 0 when pressed; 0 means they read 1 when pressed.
REQ-004 SHALL have parameter LONG_PRESS_CYCLES, default 40000000, meaning hold time in cycles before the long-press pulse (>=1).
REQ-005 SHALL have parameter REPEAT_DELAY, default 20000000, meaning cycles from press to the first auto-repeat pulse (>=1).
REQ-006 SHALL have parameter REPEAT_PERIOD, default 4000000, meaning cycles between subsequent auto-repeat pulses (>=1).
REQ-007 SHALL have parameter REPEAT_EN, default all ones [N_BTN], meaning the per-channel auto-repeat enable mask.
REQ-008 SHALL have port i_clk, input, 1 bit: the single clock; all logic is in this domain.
REQ-009 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port i_btn, input, N_BTN bits: raw asynchronous button levels.
REQ-011 SHALL have port o_btn, output, N_BTN bits: debounced level, 1 = pressed.
REQ-012 SHALL have port o_press, output, N_BTN bits: one-cycle pulse on each accepted press.
REQ-013 SHALL have port o_release, output, N_BTN bits: one-cycle pulse on each accepted release.
REQ-014 SHALL have port o_long, output, N_BTN bits: one-cycle pulse when a press has been held LONG_PRESS_CYCLES.
REQ-015 SHALL have port o_repeat, output, N_BTN bits: auto-repeat pulse train.

Function
REQ-016 SHALL pass each i_btn bit through a 2-flop synchroniser, then normalise polarity so that pressed = 1.
REQ-017 SHALL compare each normalised bit every cycle with that channel's stable state; a differing sample increments the debounce counter and a matching sample clears it.
REQ-018 SHALL toggle the stable state and clear the counter when MIN_PULSE_WIDTH consecutive differing samples have occurred; raw edge to o_btn change = 2 + MIN_PULSE_WIDTH cycles.
REQ-019 SHALL assert o_press (o_release) for exactly the first cycle in which o_btn reads 1 (0); all outputs are registered.
REQ-020 SHALL treat a glitch shorter than MIN_PULSE_WIDTH synchronised cycles as no event: no output changes and the counter restarts.
REQ-021 SHALL define press cycle P as the cycle o_press is high and hold count h = cycle - P; h saturates at its maximum while the button is held.
REQ-022 SHALL assert o_long in cycle P + LONG_PRESS_CYCLES at most once per press, and not at all if the release occurs earlier.
REQ-023 SHALL, when REPEAT_EN[i] = 1, pulse o_repeat[i] at P, P+REPEAT_DELAY, and P+REPEAT_DELAY+k*REPEAT_PERIOD (k>=1) while held; when REPEAT_EN[i] = 0, o_repeat[i] stays 0.
REQ-024 SHALL clear the hold and repeat timers in the o_release cycle, with no o_long or o_repeat pulse in that cycle or afterwards until the next press.
REQ-025 SHALL keep channels fully independent; simultaneous events on any set of channels produce their pulses in the same cycle.
REQ-026 SHALL size every counter with $clog2 of its terminal value; counters never wrap.

Reset
REQ-027 SHALL, while i_rst = 1, force o_btn, o_press, o_release, o_long and o_repeat to 0, all counters to 0, stable state to released, and synchroniser flops to the released raw level (ACTIVE_LOW ? 1 : 0).
REQ-028 SHALL, for a button held across reset deassertion, report it as a fresh press 2 + MIN_PULSE_WIDTH cycles after release, with full timer behaviour.
REQ-029 SHALL, on reset asserted mid-debounce or mid-hold, discard all in-progress state with no pending pulse emitted.

Structure
REQ-030 SHALL place the parameter defaults and the counter-width helper function in shared package btn_ctrl_pkg.
REQ-031 SHALL implement one channel in sub-module btn_ctrl_chan, instantiated N_BTN times by a generate loop.

Verification (MIN_PULSE_WIDTH=4, LONG_PRESS_CYCLES=20, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1, N_BTN=2)
REQ-032 SHALL cover: i_btn[0] falls at cycle 0 and is held 50 cycles -> o_btn[0] rises at cycle 6, o_press at 6, o_repeat at 6, 16, 19, 22, ..., o_long at 26 only.
REQ-033 SHALL cover: i_btn[0] low for 3 cycles, then high -> no output activity at all.
REQ-034 SHALL cover: a press held 15 cycles after P, then released -> o_release 6 cycles after the raw rise, no o_long, and no o_repeat after the release.
REQ-035 SHALL cover: both channels pressed in the same cycle with REPEAT_EN=2'b01 -> identical o_press timing on both, o_repeat only on bit 0.
REQ-036 SHALL cover: i_rst pulsed at P+5 while held -> all outputs 0 during reset; a new o_press 6 cycles after deassertion; o_long 20 cycles after that press.
